// File: rtl/button_debouncer_if.sv
// Signal bundle between the enable generator / raw button pin and the debouncer.
// master drives the timebase and raw input; slave is the debouncer itself.
interface button_debouncer_if;
    logic tick_en;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_repeat;

    modport master (
        output tick_en, btn_in,
        input  btn_level, btn_press, btn_release, btn_repeat
    );

    modport slave (
        input  tick_en, btn_in,
        output btn_level, btn_press, btn_release, btn_repeat
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer timed by the enable generator's tick_en pulse.
// Optional auto-repeat strobe is compiled in with BUTTON_DEBOUNCER_REPEAT_EN.
//
// state        | meaning
// RELEASED     | accepted level 0, input agrees
// PRESS_PEND   | input went 1, counting stable ticks
// PRESSED      | accepted level 1, input agrees
// RELEASE_PEND | input went 0, counting stable ticks
module button_debouncer #(
    parameter int STABLE_TICKS  = 20,
    parameter bit ACTIVE_LOW_IN = 1'b0,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    button_debouncer_if.slave   bus
);

    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    if (STABLE_TICKS < 1 || STABLE_TICKS > 65535 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_debouncer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    state_t           state;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             s_in;

    assign s_in = sync_q[1] ^ ACTIVE_LOW_IN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RELEASED;
            sync_q    <= 2'b00;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], bus.btn_in};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state)
                RELEASED: begin
                    if (s_in) begin
                        state <= PRESS_PEND;
                        cnt   <= '0;
                    end
                end
                PRESS_PEND: begin
                    if (!s_in) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (bus.tick_en) begin
                        if (cnt == CNT_LAST) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!s_in) begin
                        state <= RELEASE_PEND;
                        cnt   <= '0;
                    end
                end
                RELEASE_PEND: begin
                    if (s_in) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (bus.tick_en) begin
                        if (cnt == CNT_LAST) begin
                            state     <= RELEASED;
                            cnt       <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_started;
    logic             rep_q;
    logic [REP_W-1:0] rep_target;

    // First pulse waits REPEAT_DELAY ticks, later ones REPEAT_PERIOD ticks.
    assign rep_target = rep_started ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt     <= '0;
            rep_started <= 1'b0;
            rep_q       <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            if (state == PRESSED && s_in) begin
                if (bus.tick_en) begin
                    if (rep_cnt + 1'b1 == rep_target) begin
                        rep_q       <= 1'b1;
                        rep_cnt     <= '0;
                        rep_started <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
            end else begin
                rep_cnt     <= '0;
                rep_started <= 1'b0;
            end
        end
    end

    assign bus.btn_repeat = rep_q;
`else
    assign bus.btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer against a run-length
// model of the debounce rules (STABLE_TICKS=4, repeat 5/3 when compiled in).
module tb_button_debouncer;

    localparam int ST = 4;
    localparam int RD = 5;
    localparam int RP = 3;

    logic clk;
    logic rst_n;
    button_debouncer_if bus ();

    button_debouncer #(
        .STABLE_TICKS (ST),
        .ACTIVE_LOW_IN(1'b0),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_press = 0;
    int n_release = 0;
    int n_repeat = 0;
    logic [3:0] obs;
    logic [3:0] exp_v;

    // Reference model: s_in is btn_in delayed by two edges. A new value is
    // accepted once ST ticks have been seen with it held, not counting the
    // edge where it first differed from the accepted level.
    logic [1:0] m_syn;
    logic m_level, m_pend, m_s;
    int   m_run, m_rep;
    logic e_level, e_press, e_release, e_repeat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_syn = 2'b00; m_level = 0; m_pend = 0; m_run = 0; m_rep = 0;
            e_level = 0; e_press = 0; e_release = 0; e_repeat = 0;
        end else begin
            m_s = m_syn[1];
            m_syn = {m_syn[0], bus.btn_in};
            e_press = 0; e_release = 0; e_repeat = 0;
            if (m_s == m_level) begin
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
                if (m_level && !m_pend && bus.tick_en) begin
                    m_rep++;
                    if (m_rep == RD || (m_rep > RD && (m_rep - RD) % RP == 0)) e_repeat = 1;
                end
`endif
                if (m_pend) m_rep = 0;
                m_pend = 0; m_run = 0;
            end else begin
                m_rep = 0;
                if (!m_pend) begin
                    m_pend = 1; m_run = 0;
                end else if (bus.tick_en) begin
                    m_run++;
                    if (m_run == ST) begin
                        m_level = m_s; m_pend = 0; m_run = 0;
                        if (m_s) e_press = 1; else e_release = 1;
                    end
                end
            end
            e_level = m_level;
        end
    end

    task automatic cyc(input logic b, input logic t);
        @(negedge clk);
        bus.btn_in = b;
        bus.tick_en = t;
        @(posedge clk);
        #2;
        obs   = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat};
        exp_v = {e_level, e_press, e_release, e_repeat};
        if (bus.btn_press) n_press++;
        if (bus.btn_release) n_release++;
        if (bus.btn_repeat) n_repeat++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0);
            checks++;
            if (obs !== 4'b0000) begin
                errors++; $display("FAIL reset_hold cycle %0d: got %b want 0000", i, obs);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_press = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0);
            checks++;
            if (obs !== exp_v || obs[3] !== 1'b0) begin
                errors++; $display("FAIL reset_exit cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_press !== 0) begin
            errors++; $display("FAIL reset_exit_press: got %0d want 0", n_press);
        end
        for (int i = 0; i < 60; i++) cyc(1'b0, (i % 10) == 0);
    endtask

    task automatic test_clean_press();
        int press_idx;
        press_idx = -1;
        n_press = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1'b1, (i % 10) == 0);
            if (obs[2] && press_idx < 0) press_idx = i;
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL clean_press cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_press !== 1 || press_idx !== 40) begin
            errors++; $display("FAIL clean_press_timing: got count %0d at %0d want 1 at 40", n_press, press_idx);
        end
        n_release = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1'b0, (i % 10) == 0);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL clean_release cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_release !== 1 || obs[3] !== 1'b0) begin
            errors++; $display("FAIL clean_release_count: got %0d level %b want 1 level 0", n_release, obs[3]);
        end
    endtask

    task automatic test_bounce();
        logic b;
        b = 1'b1;
        n_press = 0; n_release = 0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0 && (i % 15) == 0) b = ~b;
            cyc(b, (i % 10) == 0);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL bounce cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_press !== 0 || n_release !== 0) begin
            errors++; $display("FAIL bounce_quiet: got press %0d release %0d want 0 0", n_press, n_release);
        end
        for (int i = 200; i < 280; i++) begin
            cyc(1'b1, (i % 10) == 0);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL bounce_settle cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_press !== 1 || obs[3] !== 1'b1) begin
            errors++; $display("FAIL bounce_press: got %0d level %b want 1 level 1", n_press, obs[3]);
        end
        for (int i = 0; i < 80; i++) cyc(1'b0, (i % 10) == 0);
    endtask

    task automatic test_glitch();
        n_press = 0; n_release = 0;
        for (int i = 0; i < 65; i++) begin
            cyc(i < 25, (i % 10) == 0);
            checks++;
            if (obs !== exp_v || obs !== 4'b0000) begin
                errors++; $display("FAIL glitch cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_press !== 0 || n_release !== 0) begin
            errors++; $display("FAIL glitch_count: got press %0d release %0d want 0 0", n_press, n_release);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        checks++;
        if (obs !== 4'b1000 || exp_v !== 4'b1000) begin
            errors++; $display("FAIL mid_reset_setup: got %b model %b want 1000", obs, exp_v);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        obs = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat};
        checks++;
        if (obs !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_async: got %b want 0000", obs);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        n_release = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1);
            checks++;
            if (obs !== exp_v || obs !== 4'b0000) begin
                errors++; $display("FAIL mid_reset_exit cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_release !== 0) begin
            errors++; $display("FAIL mid_reset_release: got %0d want 0", n_release);
        end
    endtask

    task automatic test_random();
        logic b;
        int   hold;
        logic t;
        b = 1'b0;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                b = $urandom_range(0, 1);
                hold = $urandom_range(1, 40);
            end
            hold--;
            t = ($urandom_range(0, 3) == 0);
            cyc(b, t);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL random cycle %0d: got %b want %b", i, obs, exp_v);
            end
            if (obs[2] && obs[1]) begin
                errors++; $display("FAIL random_both_strobes cycle %0d: got %b", i, obs);
            end
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
    endtask

    task automatic test_repeat();
        int waited;
        logic want;
        waited = 0;
        n_press = 0;
        while (n_press == 0 && waited < 30) begin
            cyc(1'b1, 1'b1);
            waited++;
        end
        checks++;
        if (n_press !== 1) begin
            errors++; $display("FAIL repeat_press_timeout: got %0d presses want 1", n_press);
        end
        for (int i = 1; i <= 14; i++) begin
            cyc(1'b1, 1'b1);
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
            want = (i >= RD) && ((i - RD) % RP == 0);
`else
            want = 1'b0;
`endif
            checks++;
            if (obs[0] !== want || obs !== exp_v) begin
                errors++; $display("FAIL repeat_tick %0d: got %b want repeat %b model %b", i, obs, want, exp_v);
            end
        end
        n_release = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b1);
            if (n_release > 0) begin
                checks++;
                if (obs[0] !== 1'b0) begin
                    errors++; $display("FAIL repeat_after_release cycle %0d: got %b", i, obs[0]);
                end
            end
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL repeat_release cycle %0d: got %b want %b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_release !== 1) begin
            errors++; $display("FAIL repeat_release_count: got %0d want 1", n_release);
        end
    endtask

    initial begin
        bus.btn_in  = 1'b0;
        bus.tick_en = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_mid_reset();
        test_random();
        test_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
